// File: rtl/pkt_serializer.sv
// pkt_serializer
//   Collects DATA_W-bit samples into a ping-pong store (one bank per packet)
//   and emits each closed bank as a framed packet:
//     HEADER(sop), SEQ, LEN, payload[0..LEN-1], CSUM(eop)
//   CSUM is the modulo-2^DATA_W sum of the payload words only.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   din, din_valid        input sample and qualifier
//   din_ready             input side can accept a sample this cycle
//   flush                 closes the current partial bank
//   dout, dout_valid      registered output word and qualifier
//   dout_ready            downstream accepts dout this cycle
//   dout_sop, dout_eop    registered flags, high with HEADER / CSUM words
module pkt_serializer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PKT_LEN = 16,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              flush,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_sop,
    output logic              dout_eop
);

    localparam int unsigned CNT_W  = $clog2(PKT_LEN + 1);
    localparam int unsigned ADDR_W = $clog2(2 * PKT_LEN);
    localparam logic [DATA_W-1:0] HDR_WORD = DATA_W'(HEADER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SEQ,
        S_LEN,
        S_DATA,
        S_CSUM
    } tx_state_t;

    // Both banks live in one array: bank b occupies [b*PKT_LEN +: PKT_LEN].
    logic [DATA_W-1:0] mem [2*PKT_LEN];

    logic [1:0]        full;
    logic [CNT_W-1:0]  len [2];
    logic [CNT_W-1:0]  count;
    logic              wr_sel;
    logic              rd_sel;
    logic [DATA_W-1:0] seq;
    logic [DATA_W-1:0] csum;
    logic [CNT_W-1:0]  rd_idx;
    tx_state_t         state;

    logic              accept;
    logic              bank_close;
    logic              out_accept;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  rd_idx_inc;
    logic [CNT_W-1:0]  rd_word;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign din_ready = ~full[wr_sel] & ~rst;

    always_comb begin
        accept     = din_valid & din_ready;
        count_inc  = count + 1'b1;
        // Flush only counts while the input side is open and the bank would
        // hold at least one word, so an empty packet can never be closed.
        bank_close = (accept & (count_inc == CNT_W'(PKT_LEN)))
                   | (din_ready & flush & (accept | (count != '0)));
        out_accept = dout_valid & dout_ready;
        rd_idx_inc = rd_idx + 1'b1;
        // Prefetch address: first payload word while leaving LEN, otherwise
        // the word after the one currently on dout.
        rd_word    = (state == S_DATA) ? rd_idx_inc : '0;
        wr_addr    = ADDR_W'(count)   + (wr_sel ? ADDR_W'(PKT_LEN) : '0);
        rd_addr    = ADDR_W'(rd_word) + (rd_sel ? ADDR_W'(PKT_LEN) : '0);
        rd_data    = mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= '0;
            len[0]     <= '0;
            len[1]     <= '0;
            count      <= '0;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            seq        <= '0;
            csum       <= '0;
            rd_idx     <= '0;
            state      <= S_IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
        end else begin
            // Write side. The bank under transmission is always full, so the
            // write side never touches rd_sel while a packet is in flight and
            // the set/clear of full[] below always target different banks.
            if (bank_close) begin
                full[wr_sel] <= 1'b1;
                len[wr_sel]  <= accept ? count_inc : count;
                wr_sel       <= ~wr_sel;
                count        <= '0;
            end else if (accept) begin
                count <= count_inc;
            end

            // Read side
            case (state)
                S_IDLE: begin
                    if (full[rd_sel]) begin
                        state      <= S_HDR;
                        dout       <= HDR_WORD;
                        dout_valid <= 1'b1;
                        dout_sop   <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (out_accept) begin
                        state    <= S_SEQ;
                        dout     <= seq;
                        dout_sop <= 1'b0;
                    end
                end
                S_SEQ: begin
                    if (out_accept) begin
                        state <= S_LEN;
                        dout  <= DATA_W'(len[rd_sel]);
                    end
                end
                S_LEN: begin
                    if (out_accept) begin
                        state  <= S_DATA;
                        dout   <= rd_data;
                        rd_idx <= '0;
                        csum   <= '0;
                    end
                end
                S_DATA: begin
                    if (out_accept) begin
                        csum   <= csum + dout;
                        rd_idx <= rd_idx_inc;
                        if (rd_idx_inc == len[rd_sel]) begin
                            state    <= S_CSUM;
                            dout     <= csum + dout;
                            dout_eop <= 1'b1;
                        end else begin
                            dout <= rd_data;
                        end
                    end
                end
                S_CSUM: begin
                    if (out_accept) begin
                        full[rd_sel] <= 1'b0;
                        rd_sel       <= ~rd_sel;
                        seq          <= seq + 1'b1;
                        dout_eop     <= 1'b0;
                        // Chain straight into the next header when the other
                        // bank is already waiting: no idle cycle between packets.
                        if (full[~rd_sel]) begin
                            state    <= S_HDR;
                            dout     <= HDR_WORD;
                            dout_sop <= 1'b1;
                        end else begin
                            state      <= S_IDLE;
                            dout_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    dout_valid <= 1'b0;
                    dout_sop   <= 1'b0;
                    dout_eop   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_serializer.sv
// tb_pkt_serializer
//   Self-checking bench for pkt_serializer (DATA_W=8, PKT_LEN=16, HEADER=A5).
//   A packet-level reference model turns accepted input words into expected
//   framed packets (queue of words with sop/eop flags); every output accept is
//   compared against it, along with handshake and timing properties.
module tb_pkt_serializer;

    localparam int unsigned DW = 8;
    localparam int unsigned PL = 16;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic [DW-1:0] din        = '0;
    logic          din_valid  = 1'b0;
    logic          din_ready;
    logic          flush      = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          dout_sop;
    logic          dout_eop;

    always #5 clk = ~clk;

    pkt_serializer #(
        .DATA_W (DW),
        .PKT_LEN(PL),
        .HEADER (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .flush     (flush),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [9:0]  exp_q[$];      // {eop, sop, word}
    logic [7:0]  partial[$];
    int unsigned pending = 0;   // closed packets whose CSUM has not been accepted
    int unsigned mseq    = 0;
    bit          in_pkt, expect_valid, prev_stall, post_rst;
    logic [7:0]  prev_dout;
    logic        prev_sop, prev_eop;
    int unsigned pkt_pos = 0;   // words of the current packet accepted so far
    logic [7:0]  last_len, last_csum;
    logic [7:0]  seq_log[$];

    task automatic close_packet();
        int unsigned sum = 0;
        exp_q.push_back({2'b01, 8'hA5});
        exp_q.push_back({2'b00, 8'(mseq)});
        exp_q.push_back({2'b00, 8'(partial.size())});
        foreach (partial[i]) begin
            exp_q.push_back({2'b00, partial[i]});
            sum += partial[i];
        end
        exp_q.push_back({2'b10, 8'(sum % 256)});
        mseq = (mseq + 1) % 256;
        pending++;
        partial.delete();
    endtask

    task automatic reset_model();
        exp_q.delete();
        partial.delete();
        seq_log.delete();
        pending      = 0;
        mseq         = 0;
        in_pkt       = 0;
        expect_valid = 0;
        prev_stall   = 0;
        pkt_pos      = 0;
    endtask

    // One clock: drive inputs just after the previous edge, check outputs,
    // advance the model, then step past the next rising edge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic f, input logic dr);
        logic       model_ready;
        logic [9:0] e;
        rst = r; din = d; din_valid = v; flush = f; dout_ready = dr;
        #1;
        model_ready = (pending < 2) && !r;
        check("din_ready", din_ready, model_ready);
        if (r) begin
            reset_model();
            post_rst = 1;
        end else begin
            if (post_rst) begin
                check("rst_valid", dout_valid, 0);
                check("rst_sop", dout_sop, 0);
                check("rst_eop", dout_eop, 0);
                post_rst = 0;
            end
            if (prev_stall) begin
                check("hold_valid", dout_valid, 1);
                check("hold_dout", dout, prev_dout);
                check("hold_sop", dout_sop, prev_sop);
                check("hold_eop", dout_eop, prev_eop);
            end
            if (expect_valid) begin
                check("valid_rise", dout_valid, 1);
                check("rise_sop", dout_sop, 1);
            end
            if (in_pkt) check("valid_cont", dout_valid, 1);
            if (exp_q.size() == 0) check("spurious", dout_valid, 0);

            expect_valid = !dout_valid && (pending > 0);
            prev_stall   = dout_valid && !dr;
            prev_dout    = dout;
            prev_sop     = dout_sop;
            prev_eop     = dout_eop;

            if (dout_valid && dr && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dout", dout, e[7:0]);
                check("sop", dout_sop, e[8]);
                check("eop", dout_eop, e[9]);
                pkt_pos = e[8] ? 1 : pkt_pos + 1;
                if (pkt_pos == 2) seq_log.push_back(dout);
                if (pkt_pos == 3) last_len = dout;
                if (e[8]) in_pkt = 1;
                if (e[9]) begin
                    last_csum = dout;
                    in_pkt    = 0;
                    pkt_pos   = 0;
                    pending--;
                    if (pending > 0) expect_valid = 1;
                end
            end

            if (v && model_ready) begin
                partial.push_back(d);
                if (partial.size() == PL || f) close_packet();
            end else if (f && model_ready && partial.size() > 0) begin
                close_packet();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1, 0, 8'h00, 0, 1);
        rst = 1'b0;
        #1;
    endtask

    task automatic drain(input bit rnd);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || pending != 0) && n < 400) begin
            cycle(0, 0, 8'h00, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        check("drain_done", exp_q.size(), 0);
        repeat (2) cycle(0, 0, 8'h00, 0, 1);
    endtask

    initial begin
        int unsigned acc;
        int unsigned n;

        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned acc;
        int unsigned n;

        @(posedge clk);
        #1;
        do_reset();
        check("reset_dout", dout, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_sop", dout_sop, 0);
        check("reset_eop", dout_eop, 0);
        check("reset_ready", din_ready, 1);

        // Full packet 0x01..0x10
        for (int i = 1; i <= 16; i++) cycle(0, 1, 8'(i), 0, 1);
        check("lat_closed_edge", dout_valid, 0);
        cycle(0, 0, 8'h00, 0, 1);
        check("lat_next_valid", dout_valid, 1);
        check("lat_next_hdr", dout, 8'hA5);
        check("lat_next_sop", dout_sop, 1);
        drain(0);
        check("full_len", last_len, 8'h10);
        check("full_csum", last_csum, 8'h88);

        // Flush of a 3-word partial, then a flush with no data
        do_reset();
        cycle(0, 1, 8'h10, 0, 1);
        cycle(0, 1, 8'h20, 0, 1);
        cycle(0, 1, 8'h30, 1, 1);
        drain(0);
        check("flush_len", last_len, 8'h03);
        check("flush_csum", last_csum, 8'h60);
        check("flush_npkt", seq_log.size(), 1);
        if (seq_log.size() >= 1) check("flush_seq", seq_log[0], 8'h00);
        cycle(0, 0, 8'h00, 1, 1);
        repeat (20) cycle(0, 0, 8'h00, 0, 1);
        check("empty_flush_npkt", seq_log.size(), 1);

        // Checksum wrap
        repeat (16) cycle(0, 1, 8'hFF, 0, 1);
        drain(0);
        check("wrap_len", last_len, 8'h10);
        check("wrap_csum", last_csum, 8'hF0);

        // Backpressure: both banks fill, header held
        do_reset();
        acc = 0;
        for (int i = 0; i < 40; i++) begin
            if (din_ready) acc++;
            cycle(0, 1, 8'(i), 0, 0);
            if (dout_valid) begin
                check("bp_hdr", dout, 8'hA5);
                check("bp_sop", dout_sop, 1);
            end
        end
        check("bp_accepted", acc, 32);
        check("bp_ready_low", din_ready, 0);
        drain(0);
        check("bp_npkt", seq_log.size(), 2);
        if (seq_log.size() == 2) begin
            check("bp_seq0", seq_log[0], 8'h00);
            check("bp_seq1", seq_log[1], 8'h01);
        end

        // Random stall over 4 packets
        do_reset();
        acc = 0;
        n   = 0;
        while (acc < 64 && n < 2000) begin
            if (din_ready) acc++;
            cycle(0, 1, 8'($urandom), 0, 1'($urandom_range(0, 1)));
            n++;
        end
        check("rs_accepted", acc, 64);
        drain(1);
        check("rs_npkt", seq_log.size(), 4);
        if (seq_log.size() == 4)
            for (int i = 0; i < 4; i++) check("rs_seq", seq_log[i], 8'(i));

        // Reset while DATA word 5 is presented
        do_reset();
        repeat (16) cycle(0, 1, 8'($urandom), 0, 1);
        n = 0;
        while (!(dout_valid && pkt_pos == 7) && n < 100) begin
            cycle(0, 0, 8'h00, 0, 1);
            n++;
        end
        check("mid_reach", pkt_pos, 7);
        cycle(1, 0, 8'h00, 0, 1);
        rst = 1'b0;
        #1;
        check("mid_valid", dout_valid, 0);
        check("mid_sop", dout_sop, 0);
        check("mid_eop", dout_eop, 0);
        check("mid_ready", din_ready, 1);
        for (int i = 0; i < 16; i++) cycle(0, 1, 8'(8'h40 + i), 0, 1);
        drain(0);
        check("mid_npkt", seq_log.size(), 1);
        if (seq_log.size() >= 1) check("mid_seq", seq_log[0], 8'h00);
        check("mid_len", last_len, 8'h10);
        check("mid_csum", last_csum, 8'h78);

        // Random traffic with flushes and stalls
        repeat (400)
            cycle(0, $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
